alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single multi-cycle 16-bit ALU between two requesters: port 0 is the CPU execute path and port 1 is the address/PC-increment unit.
- Arbitrates between them round-robin and drives the ALU's start/ir/a/b/oe/carryin.
- Holds the ALU inputs stable for the whole operation, then captures the result and flags into a per-port response.
- Owns the architectural flags register (Z, N, C, V), which feeds carry back into the ALU.

Parameters:
- ALU_LATENCY, 6, cycles from the start-pulse cycle to the first cycle the ALU result/carry/overflow are final.
- NREQ, 2, number of requesters (fixed at 2; index 0 wins the first tie after reset).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-port request, level; held until that port's ack.
- req_ir  in  2x10  per-port ALU opcode.
- req_a  in  2x16  per-port operand A.
- req_b  in  2x16  per-port operand B.
- req_upd_flags  in  2  per-port enable for writing the flags register on completion.
- ack  out  2  one-cycle completion pulse per port.
- rsp_data  out  16  result; valid in the ack cycle and held until the next capture.
- flags  out  4  {Z,N,C,V} architectural flags.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_ir  out  10  opcode to the ALU.
- alu_a  out  16  operand A to the ALU.
- alu_b  out  16  operand B to the ALU.
- alu_oe  out  1  ALU output enable.
- alu_carryin  out  1  equals flags C.
- alu_out  in  16  ALU result.
- alu_carry  in  1  ALU carry out.
- alu_over  in  1  ALU overflow.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values, asynchronous: state=IDLE, ack=0, rsp_data=0, flags=0, alu_start=0, alu_oe=0, alu_ir/a/b=0, last_grant=1 (so port 0 wins the first tie), cnt=0.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - If any req bit is set and that port's ack is not asserted this cycle, grant one port.
  - With one request pending, grant it.
  - With both pending, grant the port not equal to last_grant.
  - On grant, latch the port's ir/a/b/upd_flags into internal operand registers that drive alu_ir/a/b, set last_grant, and go to ISSUE.
- ISSUE: alu_start=1 for exactly this cycle. cnt loads ALU_LATENCY-1. Go to WAIT.
- WAIT:
  - cnt decrements each cycle; alu_ir/a/b stay constant.
  - When cnt==1, go to CAPTURE. Setting ALU_LATENCY=2 therefore makes WAIT last exactly one cycle.
- CAPTURE: this state is entered exactly ALU_LATENCY cycles after the ISSUE cycle.
  - alu_oe=1 (combinational in this state only).
  - rsp_data<=alu_out.
  - ack[granted] pulses in the following cycle, aligned with rsp_data valid.
  - If the latched upd_flags=1:
    - Z<=(alu_out==0)
    - N<=alu_out[15]
    - C<=alu_carry
    - V<=alu_over
  - Otherwise flags are unchanged. Go to IDLE.
- Operation length: minimum ALU_LATENCY+3 cycles per operation, from grant to ack. Back-to-back requests from different ports alternate strictly.
- Request masking: a port whose ack is high in a cycle is ignored for arbitration that cycle. This stops a stale req from being double-granted.
- req/operand changes on a non-granted port while busy have no effect; the port simply waits.
- Deassertion of a granted req mid-operation is illegal. The operation still completes and ack still pulses.
- alu_carryin is sampled by the ALU during the operation. Flags only change in CAPTURE, so carryin is stable for the whole operation.
- Reset mid-operation:
  - All state clears immediately and no ack is issued.
  - Any outstanding request must be re-arbitrated after reset release (req is level, so a port still requesting is granted again).
- Widths:
  - Z is computed over all 16 bits.
  - No truncation; operands pass through unchanged.

Test Plan:
- Single request: port0 sends ir=ADD, a=0x0003, b=0x0004, upd=1 -> ack[0] arrives ALU_LATENCY+3 cycles after req; rsp_data=0x0007; flags Z=0 N=0 C=0 V=0; alu_start high for exactly 1 cycle.
- Flag update: port0 sends a=0xFFFF, b=0x0001 ADD, upd=1 -> rsp_data=0x0000, Z=1, C=1. Repeat with upd=0 and a=0x0001 -> flags unchanged.
- Contention: both ports request in the same cycle after reset -> port0 is served first, then port1, with no idle gap beyond one cycle. With both held continuously, acks alternate 0,1,0,1.
- Operand stability: port1 changes req_a every cycle while port0 is being served -> alu_a equals port0's latched value throughout ISSUE..CAPTURE.
- Reset mid-operation: assert rst during WAIT -> busy=0, ack=0, flags=0 immediately. After release, the held req is re-granted and completes with the correct result.
- Overflow: port1 sends a=0x7FFF, b=0x0001 ADD, upd=1 -> rsp_data=0x8000, N=1, V=1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: per-port request, operands and the
// shared response. The requester block drives the master side, the arbiter
// sits on the slave side.
interface alu_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0][9:0]   req_ir;
   logic [NREQ-1:0][15:0]  req_a;
   logic [NREQ-1:0][15:0]  req_b;
   logic [NREQ-1:0]        req_upd_flags;
   logic [NREQ-1:0]        ack;
   logic [15:0]            rsp_data;

   modport master (
      output req, req_ir, req_a, req_b, req_upd_flags,
      input  ack, rsp_data
   );

   modport slave (
      input  req, req_ir, req_a, req_b, req_upd_flags,
      output ack, rsp_data
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin owner of the shared multi-cycle 16-bit ALU. Port 0 is the CPU
// execute path, port 1 the address/PC-increment unit. One operation is in
// flight at a time: operands are latched at grant and held on the ALU inputs
// until the result is captured ALU_LATENCY cycles after the start pulse.
// The architectural flags {Z,N,C,V} live here and C feeds the ALU carry-in.
module alu_arbiter #(
   parameter int ALU_LATENCY = 6,   // start-pulse cycle to first cycle with final result; must be >= 2
   parameter int NREQ        = 2    // fixed at 2; index 0 wins the first tie after reset
) (
   input  logic              clk,
   input  logic              rst,
   alu_arbiter_if.slave      bus,
   output logic [3:0]        flags,
   output logic              alu_start,
   output logic [9:0]        alu_ir,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   output logic              alu_oe,
   output logic              alu_carryin,
   input  logic [15:0]       alu_out,
   input  logic              alu_carry,
   input  logic              alu_over,
   output logic              busy
);

   localparam int CW = $clog2(ALU_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t state, state_nx;

   // Local copies of the requester bus so per-port selects stay plain arrays.
   logic [NREQ-1:0]        p_req;
   logic [NREQ-1:0][9:0]   p_ir;
   logic [NREQ-1:0][15:0]  p_a;
   logic [NREQ-1:0][15:0]  p_b;
   logic [NREQ-1:0]        p_upd;

   assign p_req = bus.req;
   assign p_ir  = bus.req_ir;
   assign p_a   = bus.req_a;
   assign p_b   = bus.req_b;
   assign p_upd = bus.req_upd_flags;

   // Latched operation and bookkeeping.
   logic [9:0]        op_ir;
   logic [15:0]       op_a;
   logic [15:0]       op_b;
   logic              op_upd;
   logic              cur;          // port currently being served
   logic              last_grant;   // port granted most recently
   logic [CW-1:0]     cnt;
   logic [NREQ-1:0]   ack_q;
   logic [15:0]       rsp_q;

   // Arbitration inputs: a port acked this cycle still shows its old req, so
   // it is masked to avoid serving the same request twice.
   logic [NREQ-1:0]   elig;
   logic              any_elig;
   logic              gnt_sel;

   assign elig     = p_req & ~ack_q;
   assign any_elig = |elig;

   // Round-robin pick: on a tie the port that did not win last time goes.
   always_comb begin
      gnt_sel = elig[1];
      if (elig[0] && elig[1])
         gnt_sel = ~last_grant;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; WAIT exits on cnt==1 so CAPTURE lands exactly
   // ALU_LATENCY cycles after ISSUE.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_elig) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (cnt == CW'(1)) state_nx = CAPTURE;
         CAPTURE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs: start pulse in ISSUE, output enable only while capturing.
   always_comb begin
      alu_start = (state == ISSUE);
      alu_oe    = (state == CAPTURE);
      busy      = (state != IDLE);
   end

   // Operand latch at grant; these registers feed the ALU for the whole op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_ir      <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_upd     <= 1'b0;
         cur        <= 1'b0;
         last_grant <= 1'b1;
      end else if (state == IDLE && any_elig) begin
         op_ir      <= p_ir[gnt_sel];
         op_a       <= p_a[gnt_sel];
         op_b       <= p_b[gnt_sel];
         op_upd     <= p_upd[gnt_sel];
         cur        <= gnt_sel;
         last_grant <= gnt_sel;
      end
   end

   // Latency counter: loaded in ISSUE, counts down through WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  cnt <= '0;
      else if (state == ISSUE)  cnt <= CW'(ALU_LATENCY - 1);
      else if (state == WAIT)   cnt <= cnt - CW'(1);
   end

   // Capture result and flags; ack is a one-cycle pulse aligned with rsp_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= '0;
         rsp_q <= '0;
         flags <= '0;
      end else begin
         ack_q <= '0;
         if (state == CAPTURE) begin
            rsp_q      <= alu_out;
            ack_q[cur] <= 1'b1;
            if (op_upd)
               flags <= {(alu_out == 16'd0), alu_out[15], alu_carry, alu_over};
         end
      end
   end

   assign bus.ack      = ack_q;
   assign bus.rsp_data = rsp_q;

   assign alu_ir      = op_ir;
   assign alu_a       = op_a;
   assign alu_b       = op_b;
   // Flags only move in CAPTURE, so carry-in is steady for the whole op.
   assign alu_carryin = flags[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural multi-cycle ALU that returns junk until
// ALU_LATENCY cycles after start, plus a sequential reference model of the
// result and the {Z,N,C,V} flags.
module tb_alu_arbiter;
   localparam int L = 6;

   localparam logic [9:0] OP_ADD = 10'h001;
   localparam logic [9:0] OP_SUB = 10'h002;
   localparam logic [9:0] OP_AND = 10'h003;
   localparam logic [9:0] OP_ADC = 10'h004;
   localparam logic [9:0] OP_XOR = 10'h005;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NREQ(2)) bus ();

   logic [3:0]  flags;
   logic        alu_start, alu_oe, alu_carryin, busy;
   logic [9:0]  alu_ir;
   logic [15:0] alu_a, alu_b, alu_out;
   logic        alu_carry, alu_over;

   alu_arbiter #(.ALU_LATENCY(L), .NREQ(2)) dut (
      .clk(clk), .rst(rst), .bus(bus), .flags(flags),
      .alu_start(alu_start), .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b),
      .alu_oe(alu_oe), .alu_carryin(alu_carryin), .alu_out(alu_out),
      .alu_carry(alu_carry), .alu_over(alu_over), .busy(busy)
   );

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_flags;

   // ALU behaviour: returns {over, carry, result}.
   function automatic logic [17:0] alu_fn(input logic [9:0] ir, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
      logic [16:0] s;
      logic v;
      s = '0;
      v = 1'b0;
      case (ir)
         OP_ADD: begin s = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (s[15] != a[15]); end
         OP_ADC: begin s = {1'b0, a} + {1'b0, b} + {16'd0, cin}; v = (a[15] == b[15]) && (s[15] != a[15]); end
         OP_SUB: begin s = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (s[15] != a[15]); end
         OP_AND: s = {1'b0, a & b};
         OP_XOR: s = {1'b0, a ^ b};
         default: s = {1'b0, a};
      endcase
      return {v, s};
   endfunction

   // Multi-cycle ALU model: final only from cycle L after the start cycle.
   int acnt;
   logic [15:0] junk;
   logic [17:0] alu_r;
   always @(posedge clk or posedge rst) begin
      if (rst) acnt <= 0;
      else if (alu_start) acnt <= 1;
      else if (acnt != 0 && acnt < 1000) acnt <= acnt + 1;
      junk <= 16'($urandom);
   end
   assign alu_r     = alu_fn(alu_ir, alu_a, alu_b, alu_carryin);
   assign alu_out   = (acnt >= L && alu_oe) ? alu_r[15:0] : junk;
   assign alu_carry = (acnt >= L) ? alu_r[16] : junk[0];
   assign alu_over  = (acnt >= L) ? alu_r[17] : junk[1];

   // Reference: the result, plus flags taken from that result when enabled.
   task automatic model_op(input logic [9:0] ir, input logic [15:0] a, input logic [15:0] b,
                           input logic upd, output logic [15:0] res);
      logic [17:0] r;
      r = alu_fn(ir, a, b, exp_flags[1]);
      res = r[15:0];
      if (upd) exp_flags = {(r[15:0] == 16'd0), r[15], r[16], r[17]};
   endtask

   task automatic rand_op(output logic [9:0] ir, output logic [15:0] a, output logic [15:0] b,
                          output logic upd);
      logic [9:0] ops [5];
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_ADC, OP_XOR};
      ir  = ops[$urandom_range(0, 4)];
      a   = 16'($urandom);
      b   = 16'($urandom);
      case ($urandom_range(0, 5))
         0: b = 16'h0000;
         1: a = 16'hFFFF;
         2: begin a = 16'h7FFF; b = 16'h0001; end
         3: b = a;
         default: ;
      endcase
      upd = 1'($urandom);
   endtask

   // Wait for ack on port p (bounded); counts cycles, start pulses and oe cycles.
   task automatic wait_ack(input int p, output int n, output int starts, output int oes, output bit ok);
      n = 0; starts = 0; oes = 0; ok = 1'b0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (alu_start) starts++;
         if (alu_oe) oes++;
         if (bus.ack[p]) begin ok = 1'b1; break; end
      end
   endtask

   // Issue one request on port p from an idle arbiter and wait for its ack.
   task automatic do_op(input int p, input logic [9:0] ir, input logic [15:0] a, input logic [15:0] b,
                        input logic upd, output int n, output int starts, output int oes, output bit ok);
      @(negedge clk);
      bus.req_ir[p] = ir;
      bus.req_a[p]  = a;
      bus.req_b[p]  = b;
      bus.req_upd_flags[p] = upd;
      bus.req[p] = 1'b1;
      wait_ack(p, n, starts, oes, ok);
      bus.req[p] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
      checks++; if (bus.rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp: got %h want 0000", bus.rsp_data); end
      checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
      checks++; if ({alu_start, alu_oe, alu_carryin} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b want 000", {alu_start, alu_oe, alu_carryin}); end
      checks++; if ({alu_ir, alu_a, alu_b} !== 42'h0) begin errors++; $display("FAIL reset_operands: got %h want 0", {alu_ir, alu_a, alu_b}); end
      rst = 1'b0;
      exp_flags = 4'h0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: busy=%b want 0", busy); end
   endtask

   task automatic test_single();
      int n, st, oe; bit ok; logic [15:0] er;
      do_op(0, OP_ADD, 16'h0003, 16'h0004, 1'b1, n, st, oe, ok);
      model_op(OP_ADD, 16'h0003, 16'h0004, 1'b1, er);
      checks++; if (!ok) begin errors++; $display("FAIL single_ack: no ack within bound"); end
      // ack shows L+2 clock edges after req is driven: grant cycle counts as the first of L+3 cycles.
      checks++; if (n != L + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", n, L + 2); end
      checks++; if (bus.rsp_data !== 16'h0007) begin errors++; $display("FAIL single_rsp: got %h want 0007", bus.rsp_data); end
      checks++; if (flags !== 4'b0000 || flags !== exp_flags) begin errors++; $display("FAIL single_flags: got %b want 0000", flags); end
      checks++; if (st != 1) begin errors++; $display("FAIL single_start_pulse: got %0d cycles want 1", st); end
      checks++; if (oe != 1) begin errors++; $display("FAIL single_oe: got %0d cycles want 1", oe); end
      checks++; if (er !== 16'h0007) begin errors++; $display("FAIL single_model: got %h want 0007", er); end
   endtask

   task automatic test_flags();
      int n, st, oe; bit ok; logic [15:0] er;
      do_op(0, OP_ADD, 16'hFFFF, 16'h0001, 1'b1, n, st, oe, ok);
      model_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, er);
      checks++; if (!ok || bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL flags_wrap_rsp: got %h want 0000", bus.rsp_data); end
      checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL flags_wrap: got %b want 1010", flags); end
      do_op(0, OP_ADD, 16'h0001, 16'h0001, 1'b0, n, st, oe, ok);
      model_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, er);
      checks++; if (!ok || bus.rsp_data !== 16'h0002) begin errors++; $display("FAIL flags_noupd_rsp: got %h want 0002", bus.rsp_data); end
      checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL flags_noupd: got %b want 1010", flags); end
      checks++; if (alu_carryin !== 1'b1) begin errors++; $display("FAIL flags_carryin: got %b want 1", alu_carryin); end
      do_op(0, OP_ADC, 16'h0001, 16'h0001, 1'b1, n, st, oe, ok);
      model_op(OP_ADC, 16'h0001, 16'h0001, 1'b1, er);
      checks++; if (!ok || bus.rsp_data !== 16'h0003) begin errors++; $display("FAIL flags_adc_rsp: got %h want 0003", bus.rsp_data); end
      checks++; if (flags !== 4'b0000 || flags !== exp_flags) begin errors++; $display("FAIL flags_adc: got %b want 0000", flags); end
   endtask

   task automatic test_overflow();
      int n, st, oe; bit ok; logic [15:0] er;
      do_op(1, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, n, st, oe, ok);
      model_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, er);
      checks++; if (!ok || bus.rsp_data !== 16'h8000) begin errors++; $display("FAIL ovf_rsp: got %h want 8000", bus.rsp_data); end
      checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL ovf_flags: got %b want 0101", flags); end
      checks++; if (n != L + 2) begin errors++; $display("FAIL ovf_latency_p1: got %0d want %0d", n, L + 2); end
   endtask

   task automatic test_stability();
      int n, st, oe, bad; bit ok; logic [15:0] er, a1;
      @(negedge clk);
      bus.req_ir[0] = OP_SUB; bus.req_a[0] = 16'h1234; bus.req_b[0] = 16'h0235;
      bus.req_upd_flags[0] = 1'b1; bus.req[0] = 1'b1;
      @(negedge clk);
      a1 = 16'($urandom);
      bus.req_ir[1] = OP_XOR; bus.req_a[1] = a1; bus.req_b[1] = 16'h00FF;
      bus.req_upd_flags[1] = 1'b1; bus.req[1] = 1'b1;
      n = 0; bad = 0; ok = 1'b0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (bus.ack[0]) begin ok = 1'b1; break; end
         if (busy && (alu_a !== 16'h1234 || alu_b !== 16'h0235 || alu_ir !== OP_SUB)) bad++;
         a1 = 16'($urandom);
         bus.req_a[1] = a1;
      end
      bus.req[0] = 1'b0;
      model_op(OP_SUB, 16'h1234, 16'h0235, 1'b1, er);
      checks++; if (!ok) begin errors++; $display("FAIL stab_ack0: no ack within bound"); end
      checks++; if (bad != 0) begin errors++; $display("FAIL stab_operands: got %0d unstable cycles want 0", bad); end
      checks++; if (bus.rsp_data !== er) begin errors++; $display("FAIL stab_rsp0: got %h want %h", bus.rsp_data, er); end
      wait_ack(1, n, st, oe, ok);
      bus.req[1] = 1'b0;
      model_op(OP_XOR, a1, 16'h00FF, 1'b1, er);
      checks++; if (!ok || n != L + 2) begin errors++; $display("FAIL stab_p1_followon: ok=%0d got %0d want %0d", ok, n, L + 2); end
      checks++; if (bus.rsp_data !== er) begin errors++; $display("FAIL stab_rsp1: got %h want %h", bus.rsp_data, er); end
      checks++; if (flags !== exp_flags) begin errors++; $display("FAIL stab_flags: got %b want %b", flags, exp_flags); end
   endtask

   task automatic test_random();
      int n, st, oe, p; bit ok; logic [15:0] er, a, b; logic [9:0] ir; logic upd;
      for (int i = 0; i < 16; i++) begin
         p = $urandom_range(0, 1);
         rand_op(ir, a, b, upd);
         do_op(p, ir, a, b, upd, n, st, oe, ok);
         model_op(ir, a, b, upd, er);
         checks++; if (!ok || bus.rsp_data !== er) begin errors++; $display("FAIL rand_rsp[%0d] p%0d ir=%h a=%h b=%h: got %h want %h", i, p, ir, a, b, bus.rsp_data, er); end
         checks++; if (flags !== exp_flags) begin errors++; $display("FAIL rand_flags[%0d]: got %b want %b", i, flags, exp_flags); end
      end
   endtask

   task automatic test_contention();
      logic [9:0] ir [2]; logic [15:0] a [2]; logic [15:0] b [2]; logic upd [2];
      int n, k, p; bit tmo; logic [15:0] er;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_flags = 4'h0;
      for (int q = 0; q < 2; q++) begin
         rand_op(ir[q], a[q], b[q], upd[q]);
         bus.req_ir[q] = ir[q]; bus.req_a[q] = a[q]; bus.req_b[q] = b[q]; bus.req_upd_flags[q] = upd[q];
      end
      bus.req = 2'b11;
      k = 0; n = 0; tmo = 1'b0;
      while (k < 5) begin
         @(negedge clk);
         n++;
         if (n > 100) begin tmo = 1'b1; break; end
         if (bus.ack != 2'b00) begin
            p = k % 2;
            model_op(ir[p], a[p], b[p], upd[p], er);
            checks++; if (bus.ack !== (2'b01 << p)) begin errors++; $display("FAIL cont_order[%0d]: got %b want %b", k, bus.ack, 2'b01 << p); end
            checks++; if (n != L + 2) begin errors++; $display("FAIL cont_gap[%0d]: got %0d want %0d", k, n, L + 2); end
            checks++; if (bus.rsp_data !== er) begin errors++; $display("FAIL cont_rsp[%0d]: got %h want %h", k, bus.rsp_data, er); end
            checks++; if (flags !== exp_flags) begin errors++; $display("FAIL cont_flags[%0d]: got %b want %b", k, flags, exp_flags); end
            if (k >= 3) bus.req[p] = 1'b0;
            else begin
               rand_op(ir[p], a[p], b[p], upd[p]);
               bus.req_ir[p] = ir[p]; bus.req_a[p] = a[p]; bus.req_b[p] = b[p]; bus.req_upd_flags[p] = upd[p];
            end
            k++;
            n = 0;
         end
      end
      bus.req = 2'b00;
      checks++; if (tmo) begin errors++; $display("FAIL cont_timeout: got %0d acks want 5", k); end
   endtask

   task automatic test_reset_mid();
      int n, st, oe; bit ok; logic [15:0] er;
      do_op(1, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, n, st, oe, ok);
      model_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, er);
      checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL rmid_pre_flags: got %b want 0101", flags); end
      @(negedge clk);
      bus.req_ir[0] = OP_ADD; bus.req_a[0] = 16'h0005; bus.req_b[0] = 16'h0006;
      bus.req_upd_flags[0] = 1'b1; bus.req[0] = 1'b1;
      n = 0;
      while (!alu_start && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || bus.ack !== 2'b00) begin errors++; $display("FAIL rmid_clear: busy=%b ack=%b want 0 00", busy, bus.ack); end
      checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rmid_flags: got %b want 0000", flags); end
      repeat (3) @(negedge clk);
      checks++; if (bus.ack !== 2'b00 || alu_start !== 1'b0) begin errors++; $display("FAIL rmid_hold: ack=%b start=%b want 00 0", bus.ack, alu_start); end
      rst = 1'b0;
      exp_flags = 4'h0;
      wait_ack(0, n, st, oe, ok);
      bus.req[0] = 1'b0;
      model_op(OP_ADD, 16'h0005, 16'h0006, 1'b1, er);
      checks++; if (!ok || n != L + 2) begin errors++; $display("FAIL rmid_regrant: ok=%0d got %0d want %0d", ok, n, L + 2); end
      checks++; if (bus.rsp_data !== 16'h000B) begin errors++; $display("FAIL rmid_rsp: got %h want 000b", bus.rsp_data); end
      checks++; if (flags !== exp_flags) begin errors++; $display("FAIL rmid_post_flags: got %b want %b", flags, exp_flags); end
   endtask

   initial begin
      bus.req = '0; bus.req_ir = '0; bus.req_a = '0; bus.req_b = '0; bus.req_upd_flags = '0;
      exp_flags = 4'h0;
      test_reset();
      test_single();
      test_flags();
      test_overflow();
      test_stability();
      test_random();
      test_contention();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
